// File: rtl/hr_window_ctrl_if.sv
// Bundles the control, sensor and result signals exchanged between the
// heart-rate measurement sequencer and its surroundings.
`timescale 1ns/1ps
interface hr_window_ctrl_if #(
  parameter int BPM_W = 8
);
  logic             start;
  logic             abort;
  logic             pulse_in;
  logic             window_done;
  logic             tick_1hz;
  logic             en_cont;
  logic             busy;
  logic [BPM_W-1:0] bpm;
  logic             bpm_valid;
  logic             overflow;

  modport master (
    output start, abort, pulse_in, window_done,
    input  tick_1hz, en_cont, busy, bpm, bpm_valid, overflow
  );

  modport slave (
    input  start, abort, pulse_in, window_done,
    output tick_1hz, en_cont, busy, bpm, bpm_valid, overflow
  );
endinterface

// File: rtl/hr_window_ctrl.sv
// Measurement sequencer: drives the 1 Hz timebase and enable of the window timer,
// counts debounced sensor beats over one window and publishes a saturating BPM.
`timescale 1ns/1ps
module hr_window_ctrl #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int BPM_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  hr_window_ctrl_if.slave bus
);

  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HALF = CLK_HZ / 2;
  localparam logic [BPM_W-1:0] BEAT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             wdSync1_q, wdSync2_q;
  logic             pulseSync1_q, pulseSync2_q;
  logic             deb_q, deb_d;
  logic [DW-1:0]    debCnt_q, debCnt_d;
  logic             beatRise;
  logic [BPM_W-1:0] beat_q, beat_d;
  logic             ovfPend_q, ovfPend_d;
  logic [BPM_W-1:0] bpm_q, bpm_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      wdSync1_q    <= 1'b0;
      wdSync2_q    <= 1'b0;
      pulseSync1_q <= 1'b0;
      pulseSync2_q <= 1'b0;
      deb_q        <= 1'b0;
      debCnt_q     <= '0;
      beat_q       <= '0;
      ovfPend_q    <= 1'b0;
      bpm_q        <= '0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      wdSync1_q    <= bus.window_done;
      wdSync2_q    <= wdSync1_q;
      pulseSync1_q <= bus.pulse_in;
      pulseSync2_q <= pulseSync1_q;
      deb_q        <= deb_d;
      debCnt_q     <= debCnt_d;
      beat_q       <= beat_d;
      ovfPend_q    <= ovfPend_d;
      bpm_q        <= bpm_d;
      ovf_q        <= ovf_d;
      valid_q      <= valid_d;
    end
  end

  // beatRise marks the cycle the debounced level flips 0->1
  always_comb begin
    deb_d    = deb_q;
    debCnt_d = '0;
    beatRise = 1'b0;
    if (pulseSync2_q != deb_q) begin
      if (debCnt_q == DW'(DEBOUNCE_CYC - 1)) begin
        deb_d    = pulseSync2_q;
        beatRise = pulseSync2_q;
      end else begin
        debCnt_d = debCnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    beat_d    = beat_q;
    ovfPend_d = ovfPend_q;
    bpm_d     = bpm_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = ARM;
      end
      ARM: begin
        presc_d   = '0;
        beat_d    = '0;
        ovfPend_d = 1'b0;
        state_d   = MEASURE;
      end
      MEASURE: begin
        presc_d = (presc_q == PW'(CLK_HZ - 1)) ? '0 : presc_q + 1'b1;
        if (beatRise) begin
          if (beat_q == BEAT_MAX) ovfPend_d = 1'b1;
          else                    beat_d    = beat_q + 1'b1;
        end
        // Result is taken on entry to LATCH so bpm and its strobe line up
        if (wdSync2_q) begin
          state_d = LATCH;
          bpm_d   = beat_d;
          ovf_d   = ovfPend_d;
          valid_d = 1'b1;
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      bpm_d   = bpm_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
    end
  end

  assign tick_d = (state_q == MEASURE) && (state_d == MEASURE) && (presc_q < PW'(HALF));

  assign bus.tick_1hz  = tick_q;
  assign bus.en_cont   = (state_q == MEASURE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.bpm       = bpm_q;
  assign bus.bpm_valid = valid_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_hr_window_ctrl.sv
// Self-checking bench for hr_window_ctrl with a behavioural window-timer model and
// a pulse-train reference that counts accepted beats directly from segment widths.
`timescale 1ns/1ps
module tb_hr_window_ctrl;

  localparam int CLK_HZ       = 10;
  localparam int DEBOUNCE_CYC = 3;
  localparam int BPM_W        = 8;

  typedef struct {
    logic lvl;
    int   dur;
  } seg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int validCount  = 0;
  int winTicks    = 1000;
  int tickCnt     = 0;
  logic tickPrev  = 1'b0;
  logic wdModel   = 1'b0;
  logic [BPM_W-1:0] lastBpm = '0;
  logic lastOvf = 1'b0;

  hr_window_ctrl_if #(.BPM_W(BPM_W)) ifc ();

  hr_window_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .BPM_W       (BPM_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  // Window timer: counts tick rising edges while enabled, done after winTicks
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tickCnt  <= 0;
      wdModel  <= 1'b0;
      tickPrev <= 1'b0;
    end else begin
      tickPrev <= ifc.tick_1hz;
      if (!ifc.en_cont) begin
        tickCnt <= 0;
        wdModel <= 1'b0;
      end else if (ifc.tick_1hz && !tickPrev) begin
        tickCnt <= tickCnt + 1;
        if (tickCnt + 1 >= winTicks) wdModel <= 1'b1;
      end
    end
  end
  assign ifc.window_done = wdModel;

  always @(posedge clk) begin
    if (ifc.bpm_valid) begin
      validCount <= validCount + 1;
      lastBpm    <= ifc.bpm;
      lastOvf    <= ifc.overflow;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doStart(output bit ok);
    ok = 1'b0;
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ifc.en_cont) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitValid(input int budget, input int base, output bit got, output bit busyAfter);
    got       = 1'b0;
    busyAfter = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (validCount != base) begin
        got       = 1'b1;
        busyAfter = ifc.busy;
        break;
      end
    end
  endtask

  task automatic runWindow(input int nClean, input bit fixedW, input bit glitchy,
                           output bit ok, output bit busyAfter,
                           output int expBpm, output bit expOvf);
    seg_t segs[$];
    int total;
    int highs;
    int base;
    bit startOk;
    bit got;
    total = 0;
    highs = 0;
    for (int i = 0; i < nClean; i++) begin
      segs.push_back('{1'b1, fixedW ? 5 : int'($urandom_range(4, 7))});
      if (glitchy) begin
        segs.push_back('{1'b0, int'($urandom_range(4, 6))});
        segs.push_back('{1'b1, int'($urandom_range(1, 2))});
        segs.push_back('{1'b0, int'($urandom_range(4, 6))});
      end else begin
        segs.push_back('{1'b0, fixedW ? 5 : int'($urandom_range(4, 7))});
      end
    end
    foreach (segs[k]) begin
      total += segs[k].dur;
      if (segs[k].lvl && segs[k].dur > DEBOUNCE_CYC) highs++;
    end
    expBpm   = (highs > 255) ? 255 : highs;
    expOvf   = (highs > 255);
    winTicks = total / CLK_HZ + 4;
    base     = validCount;
    doStart(startOk);
    foreach (segs[k]) begin
      ifc.pulse_in = segs[k].lvl;
      repeat (segs[k].dur) @(negedge clk);
    end
    ifc.pulse_in = 1'b0;
    waitValid(winTicks * CLK_HZ + 100, base, got, busyAfter);
    ok = startOk && got;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (ifc.tick_1hz !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tick: got %b, want 0", ifc.tick_1hz); end
    if (ifc.en_cont !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en_cont: got %b, want 0", ifc.en_cont); end
    if (ifc.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, want 0", ifc.busy); end
    if (ifc.bpm !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_bpm: got %0d, want 0", ifc.bpm); end
    if (ifc.bpm_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, want 0", ifc.bpm_valid); end
    if (ifc.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b, want 0", ifc.overflow); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_tick_period;
    bit ok;
    bit got;
    bit busyAfter;
    logic expTick;
    int base;
    winTicks = 8;
    base = validCount;
    doStart(ok);
    vectors++;
    if (!ok || ifc.tick_1hz !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tick_entry: started %b tick %b, want started 1 tick 0", ok, ifc.tick_1hz);
    end
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      expTick = (((j - 1) % CLK_HZ) < (CLK_HZ / 2));
      vectors++;
      if (ifc.tick_1hz !== expTick) begin
        miscompares++;
        $display("[TB] FAIL tick_shape: cycle %0d got %b, want %b", j, ifc.tick_1hz, expTick);
      end
    end
    waitValid(300, base, got, busyAfter);
    vectors++;
    if (!got || lastBpm !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL tick_window_result: valid %b bpm %0d, want valid 1 bpm 0", got, lastBpm);
    end
  endtask

  task automatic test_clean;
    bit ok;
    bit busyAfter;
    int expBpm;
    bit expOvf;
    int base;
    base = validCount;
    runWindow(72, 1'b1, 1'b0, ok, busyAfter, expBpm, expOvf);
    repeat (20) @(negedge clk);
    vectors += 4;
    if (!ok) begin miscompares++; $display("[TB] FAIL clean_done: got %b, want 1", ok); end
    if (lastBpm !== expBpm[7:0] || expBpm != 72) begin miscompares++; $display("[TB] FAIL clean_bpm: got %0d, want 72", lastBpm); end
    if (lastOvf !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_overflow: got %b, want 0", lastOvf); end
    if (busyAfter !== 1'b0 || validCount - base != 1) begin
      miscompares++;
      $display("[TB] FAIL clean_strobe: busy %b valids %0d, want busy 0 valids 1", busyAfter, validCount - base);
    end
  endtask

  task automatic test_abort;
    bit ok;
    int base;
    winTicks = 100;
    base = validCount;
    doStart(ok);
    for (int i = 0; i < 3; i++) begin
      ifc.pulse_in = 1'b1;
      repeat (5) @(negedge clk);
      ifc.pulse_in = 1'b0;
      repeat (5) @(negedge clk);
    end
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    vectors += 4;
    if (ifc.tick_1hz !== 1'b0 || ifc.en_cont !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_timer: tick %b en_cont %b, want 0 0", ifc.tick_1hz, ifc.en_cont);
    end
    if (ifc.busy !== 1'b0 || !ok) begin miscompares++; $display("[TB] FAIL abort_busy: got %b, want 0", ifc.busy); end
    repeat (60) @(negedge clk);
    if (ifc.bpm !== 8'd72) begin miscompares++; $display("[TB] FAIL abort_bpm: got %0d, want 72", ifc.bpm); end
    if (validCount != base) begin miscompares++; $display("[TB] FAIL abort_valid: got %0d strobes, want 0", validCount - base); end
  endtask

  task automatic test_restart_ignored;
    bit ok;
    bit got;
    bit busyAfter;
    int base;
    winTicks = 20;
    base = validCount;
    doStart(ok);
    for (int i = 0; i < 4; i++) begin
      ifc.pulse_in = 1'b1;
      ifc.start    = 1'b1;
      @(negedge clk);
      ifc.start    = 1'b0;
      repeat (4) @(negedge clk);
      ifc.pulse_in = 1'b0;
      repeat (6) @(negedge clk);
    end
    waitValid(400, base, got, busyAfter);
    repeat (40) @(negedge clk);
    vectors += 2;
    if (!ok || !got || validCount - base != 1) begin
      miscompares++;
      $display("[TB] FAIL restart_strobes: got %0d, want 1", validCount - base);
    end
    if (lastBpm !== 8'd4) begin miscompares++; $display("[TB] FAIL restart_bpm: got %0d, want 4", lastBpm); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit busyAfter;
    int expBpm;
    bit expOvf;
    winTicks = 50;
    doStart(ok);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({ifc.tick_1hz, ifc.en_cont, ifc.busy, ifc.bpm_valid, ifc.overflow} !== 5'b0 || ifc.bpm !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: tick %b en %b busy %b valid %b ovf %b bpm %0d, want all 0",
               ifc.tick_1hz, ifc.en_cont, ifc.busy, ifc.bpm_valid, ifc.overflow, ifc.bpm);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    runWindow(12, 1'b0, 1'b0, ok, busyAfter, expBpm, expOvf);
    vectors++;
    if (!ok || lastBpm !== expBpm[7:0] || lastOvf !== expOvf) begin
      miscompares++;
      $display("[TB] FAIL midreset_remeasure: bpm %0d ovf %b, want %0d %b", lastBpm, lastOvf, expBpm, expOvf);
    end
  endtask

  task automatic test_glitch;
    bit ok;
    bit busyAfter;
    int expBpm;
    bit expOvf;
    runWindow(10, 1'b0, 1'b1, ok, busyAfter, expBpm, expOvf);
    vectors++;
    if (!ok || lastBpm !== 8'd10 || expBpm != 10) begin
      miscompares++;
      $display("[TB] FAIL glitch_bpm: got %0d, want 10", lastBpm);
    end
  endtask

  task automatic test_saturate;
    bit ok;
    bit busyAfter;
    int expBpm;
    bit expOvf;
    runWindow(300, 1'b1, 1'b0, ok, busyAfter, expBpm, expOvf);
    vectors += 2;
    if (!ok || lastBpm !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_bpm: got %0d, want 255", lastBpm); end
    if (lastOvf !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_overflow: got %b, want 1", lastOvf); end
  endtask

  task automatic test_random;
    bit ok;
    bit busyAfter;
    int expBpm;
    bit expOvf;
    for (int r = 0; r < 4; r++) begin
      runWindow(int'($urandom_range(5, 40)), 1'b0, 1'($urandom_range(0, 1)), ok, busyAfter, expBpm, expOvf);
      vectors++;
      if (!ok || lastBpm !== expBpm[7:0] || lastOvf !== expOvf || busyAfter !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL random_window%0d: bpm %0d ovf %b busy %b, want %0d %b 0",
                 r, lastBpm, lastOvf, busyAfter, expBpm, expOvf);
      end
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    ifc.start    = 1'b0;
    ifc.abort    = 1'b0;
    ifc.pulse_in = 1'b0;
    test_reset;
    test_tick_period;
    test_clean;
    test_abort;
    test_restart_ignored;
    test_reset_mid;
    test_glitch;
    test_saturate;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
